// File: rtl/automat_tabelar.sv
// Table-driven Mealy automaton: next state and outputs come from a writable
// {state, x} -> {next, out} table, with run/step control, restart and error trapping.
module automat_tabelar #(
    parameter int IN_W    = 2,
    parameter int OUT_W   = 9,
    parameter int ST_W    = 4,
    parameter int NUM_ST  = 11,
    parameter int INIT_ST = 0,
    parameter int OUT_REG = 0,
    parameter int CNT_W   = 16
) (
    input  logic                  clk,
    input  logic                  res,
    input  logic [IN_W-1:0]       x,
    input  logic                  run,
    input  logic                  step,
    input  logic                  restart,
    input  logic                  cfg_we,
    input  logic [ST_W+IN_W-1:0]  cfg_addr,
    input  logic [ST_W+OUT_W-1:0] cfg_data,
    output logic                  cfg_rej,
    output logic [OUT_W-1:0]      t,
    output logic [ST_W-1:0]       state,
    output logic                  err,
    output logic [CNT_W-1:0]      tr_cnt
);

    localparam int AW    = ST_W + IN_W;
    localparam int DEPTH = 1 << AW;
    localparam int EW    = ST_W + OUT_W;
    localparam logic [ST_W-1:0]  INIT_S   = ST_W'(INIT_ST);
    localparam logic [ST_W:0]    NUM_ST_L = (ST_W+1)'(NUM_ST);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // NUM_ST may equal 2^ST_W, so compare with one extra bit of headroom
    function automatic logic legal_st(input logic [ST_W-1:0] s);
        return ({1'b0, s} < NUM_ST_L);
    endfunction

    if ((INIT_ST >= NUM_ST) || (NUM_ST > (1 << ST_W)) || (NUM_ST < 1)) begin : g_param_check
        $error("automat_tabelar: INIT_ST must be < NUM_ST and NUM_ST <= 2**ST_W");
    end

    logic [EW-1:0]    r_table [DEPTH];
    logic [ST_W-1:0]  r_state;
    logic             r_err;
    logic [CNT_W-1:0] r_tr_cnt;
    logic             r_cfg_rej;

    logic [EW-1:0]    w_entry;
    logic [ST_W-1:0]  w_next_st;
    logic [OUT_W-1:0] w_out;
    logic             w_adv;
    logic             w_fire;
    logic             w_take;
    logic             w_trap;
    logic             w_cfg_ok;
    logic [ST_W-1:0]  w_state_nxt;
    logic             w_err_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [OUT_W-1:0] w_t_comb;

    assign w_entry   = r_table[{r_state, x}];
    assign w_next_st = w_entry[EW-1:OUT_W];
    assign w_out     = w_entry[OUT_W-1:0];
    // run wins over step, so the OR covers both cases
    assign w_adv     = run | step;
    assign w_fire    = w_adv & ~r_err & ~restart;
    assign w_take    = w_fire & legal_st(w_next_st);
    assign w_trap    = w_fire & ~legal_st(w_next_st);
    assign w_cfg_ok  = cfg_we & ~run & ~step & legal_st(cfg_addr[AW-1:IN_W]);

    // Transition table storage, cleared by reset
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (w_cfg_ok) begin
            r_table[cfg_addr] <= cfg_data;
        end
    end

    // Rejected-write pulse for the cycle after the attempt
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_cfg_rej <= 1'b0;
        end else begin
            r_cfg_rej <= cfg_we & ~w_cfg_ok;
        end
    end

    // State, error flag and transition counter registers
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state  <= INIT_S;
            r_err    <= 1'b0;
            r_tr_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_err    <= w_err_nxt;
            r_tr_cnt <= w_cnt_nxt;
        end
    end

    // Next-state, error and counter update
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_tr_cnt;
        if (restart) begin
            w_state_nxt = INIT_S;
            w_err_nxt   = 1'b0;
            w_cnt_nxt   = '0;
        end else if (w_take) begin
            w_state_nxt = w_next_st;
            w_err_nxt   = r_err;
            w_cnt_nxt   = (r_tr_cnt == CNT_MAX) ? r_tr_cnt : r_tr_cnt + CNT_W'(1);
        end else if (w_trap) begin
            w_state_nxt = r_state;
            w_err_nxt   = 1'b1;
            w_cnt_nxt   = r_tr_cnt;
        end else begin
            w_state_nxt = r_state;
            w_err_nxt   = r_err;
            w_cnt_nxt   = r_tr_cnt;
        end
    end

    // Mealy output, forced to zero while trapped
    always_comb begin
        w_t_comb = '0;
        if (r_err) begin
            w_t_comb = '0;
        end else begin
            w_t_comb = w_out;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic [OUT_W-1:0] r_t;

        // Registered output: loads on taken transitions, zero on trap or restart
        always_ff @(posedge clk or negedge res) begin
            if (!res) begin
                r_t <= '0;
            end else if (restart || w_trap) begin
                r_t <= '0;
            end else if (w_take) begin
                r_t <= w_t_comb;
            end else begin
                r_t <= r_t;
            end
        end

        assign t = r_t;
    end else begin : g_out_comb
        assign t = w_t_comb;
    end

    assign state   = r_state;
    assign err     = r_err;
    assign tr_cnt  = r_tr_cnt;
    assign cfg_rej = r_cfg_rej;

endmodule

// File: tb/tb_automat_tabelar.sv
// Directed bench for automat_tabelar: a combinational-output instance (A) and a
// registered-output instance with a 4-bit counter (B) share all inputs.
module tb_automat_tabelar;

    logic       clk = 1'b0;
    logic       res;
    logic [1:0] x;
    logic       run, step, restart, cfg_we;
    logic [5:0] cfg_addr;
    logic [12:0] cfg_data;

    logic       a_rej, a_err, b_rej, b_err;
    logic [8:0] a_t, b_t;
    logic [3:0] a_state, b_state;
    logic [15:0] a_tr;
    logic [3:0]  b_tr;

    automat_tabelar #(.OUT_REG(0), .CNT_W(16)) u_a (
        .clk(clk), .res(res), .x(x), .run(run), .step(step), .restart(restart),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_rej(a_rej), .t(a_t), .state(a_state), .err(a_err), .tr_cnt(a_tr));

    automat_tabelar #(.OUT_REG(1), .CNT_W(4)) u_b (
        .clk(clk), .res(res), .x(x), .run(run), .step(step), .restart(restart),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_rej(b_rej), .t(b_t), .state(b_state), .err(b_err), .tr_cnt(b_tr));

    always #5 clk = ~clk;

    localparam int A_ST = 0, A_T = 1, A_ERR = 2, A_TR = 3, A_REJ = 4;
    localparam int B_ST = 5, B_T = 6, B_ERR = 7, B_TR = 8, B_REJ = 9;

    typedef struct {
        int          id;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t q[$];
    event chk_ev;
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [31:0] actual(input int id);
        case (id)
            A_ST:    return 32'(a_state);
            A_T:     return 32'(a_t);
            A_ERR:   return 32'(a_err);
            A_TR:    return 32'(a_tr);
            A_REJ:   return 32'(a_rej);
            B_ST:    return 32'(b_state);
            B_T:     return 32'(b_t);
            B_ERR:   return 32'(b_err);
            B_TR:    return 32'(b_tr);
            B_REJ:   return 32'(b_rej);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expect_v(input int id, input logic [31:0] v, input string nm);
        exp_t e;
        e.id = id; e.val = v; e.name = nm;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Monitor: drains expectations at each negedge or on an explicit mid-cycle request
    exp_t        m_e;
    logic [31:0] m_act;
    initial begin
        forever begin
            @(negedge clk or chk_ev);
            while (q.size() > 0) begin
                m_e   = q.pop_front();
                m_act = actual(m_e.id);
                n_chk++;
                if (m_act === m_e.val) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got %0h expected %0h", m_e.name, m_act, m_e.val);
                end
            end
        end
    end

    initial begin
        res = 1'b0; x = 2'b11; run = 1'b1; step = 1'b0; restart = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;

        repeat (3) cyc();
        expect_v(A_ST, 0, "rst_a_state"); expect_v(A_T, 0, "rst_a_t");
        expect_v(A_ERR, 0, "rst_a_err"); expect_v(A_TR, 0, "rst_a_tr");
        expect_v(A_REJ, 0, "rst_a_rej"); expect_v(B_T, 0, "rst_b_t");
        expect_v(B_TR, 0, "rst_b_tr");
        cyc();
        res = 1'b1;
        repeat (5) cyc();
        run = 1'b0;
        expect_v(A_ST, 0, "empty_state"); expect_v(A_TR, 5, "empty_tr_a");
        expect_v(B_TR, 5, "empty_tr_b");

        // Program the 11-state ring on x=01
        for (int s = 0; s < 11; s++) begin
            cfg_we   = 1'b1;
            cfg_addr = {4'(s), 2'b01};
            cfg_data = {4'((s + 1) % 11), 9'(1 << (s % 9))};
            cyc();
        end
        cfg_we = 1'b0;
        expect_v(A_REJ, 0, "ring_write_rej");
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        x = 2'b01; run = 1'b1;
        expect_v(A_ST, 0, "ring_s0"); expect_v(A_T, 1, "ring_t0"); expect_v(B_T, 0, "ring_bt0");
        for (int k = 1; k <= 11; k++) begin
            cyc();
            expect_v(A_ST, 32'(k % 11), $sformatf("ring_a_state_%0d", k));
            expect_v(A_T, 32'(1 << ((k % 11) % 9)), $sformatf("ring_a_t_%0d", k));
            expect_v(B_ST, 32'(k % 11), $sformatf("ring_b_state_%0d", k));
            expect_v(B_T, 32'(1 << ((k - 1) % 9)), $sformatf("ring_b_t_%0d", k));
        end
        run = 1'b0;
        expect_v(A_TR, 11, "ring_tr_a"); expect_v(B_TR, 11, "ring_tr_b");

        // Single-step
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
            cyc();
            expect_v(A_ST, 32'(i), $sformatf("step_state_%0d", i));
        end
        expect_v(A_TR, 3, "step_tr"); expect_v(A_T, 8, "step_a_t"); expect_v(B_T, 4, "step_b_t");
        step = 1'b1; run = 1'b1;
        cyc();
        cyc();
        step = 1'b0; run = 1'b0;
        expect_v(A_ST, 5, "steprun_state"); expect_v(A_TR, 5, "steprun_tr");

        // Illegal transition trap
        cfg_we = 1'b1; cfg_addr = {4'd3, 2'b00}; cfg_data = {4'd12, 9'h1FF};
        cyc();
        cfg_we = 1'b0;
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        x = 2'b01; run = 1'b1;
        repeat (3) cyc();
        x = 2'b00;
        cyc();
        expect_v(A_ERR, 1, "trap_err"); expect_v(A_ST, 3, "trap_state");
        expect_v(A_T, 0, "trap_a_t"); expect_v(A_TR, 3, "trap_tr");
        expect_v(B_ERR, 1, "trap_b_err"); expect_v(B_T, 0, "trap_b_t");
        cyc();
        expect_v(A_ST, 3, "trap_hold_state"); expect_v(A_TR, 3, "trap_hold_tr");
        restart = 1'b1; run = 1'b0;
        cyc();
        restart = 1'b0;
        expect_v(A_ST, 0, "restart_state"); expect_v(A_ERR, 0, "restart_err");
        expect_v(A_TR, 0, "restart_tr"); expect_v(B_TR, 0, "restart_b_tr");

        // Config rejection
        cfg_we = 1'b1; cfg_addr = {4'd0, 2'b10}; cfg_data = {4'd5, 9'h0AA};
        run = 1'b1; x = 2'b01;
        cyc();
        cfg_we = 1'b0; run = 1'b0;
        expect_v(A_REJ, 1, "rej_run_a"); expect_v(B_REJ, 1, "rej_run_b");
        cyc();
        expect_v(A_REJ, 0, "rej_pulse_end");
        restart = 1'b1;
        cyc();
        restart = 1'b0; x = 2'b10;
        expect_v(A_T, 0, "rej_table_kept"); expect_v(A_ST, 0, "rej_state0");
        cfg_we = 1'b1; cfg_addr = {4'd13, 2'b00}; cfg_data = {4'd1, 9'h155};
        cyc();
        cfg_we = 1'b0;
        expect_v(A_REJ, 1, "rej_bad_state");
        cyc();
        cfg_we = 1'b1; cfg_addr = {4'd0, 2'b10}; cfg_data = {4'd5, 9'h0AA};
        cyc();
        cfg_we = 1'b0;
        expect_v(A_REJ, 0, "valid_write_rej"); expect_v(A_T, 32'h0AA, "valid_write_read");
        expect_v(A_ST, 0, "write_keeps_state"); expect_v(A_TR, 0, "write_keeps_tr");

        // Saturation (0 <-> 5 on x=10), then async reset between edges
        run = 1'b1;
        repeat (20) cyc();
        run = 1'b0;
        expect_v(A_TR, 20, "sat_a_tr"); expect_v(B_TR, 15, "sat_b_tr");
        @(negedge clk);
        #1;
        res = 1'b0;
        expect_v(A_TR, 0, "async_a_tr"); expect_v(B_TR, 0, "async_b_tr");
        expect_v(A_ST, 0, "async_a_state"); expect_v(B_T, 0, "async_b_t");
        #1;
        -> chk_ev;
        cyc();
        res = 1'b1;
        expect_v(A_T, 0, "table_cleared");

        repeat (3) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            $display("FAIL drain: got %0d pending expected 0", q.size());
            n_chk++;
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
